// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 types, constants and GF(2^8) helpers.
// Contents: NR, RCON_INIT, aes_block_t, fsm_e {IDLE, RUN}, xtime, gmul, sbox, byte_at.
// byte_at(b, i) returns byte i of a block, byte 0 being bits [127:120].
package aes_pkg;
  localparam int NR = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;
  typedef logic [127:0] aes_block_t;
  typedef enum logic {IDLE, RUN} fsm_e;
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      p = p ^ (b[k] ? x : 8'h00);
      x = xtime(x);
    end
    return p;
  endfunction
  // Multiplicative inverse is a^254 (0 maps to 0), followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq, inv;
    sq = a;
    inv = 8'h01;
    for (int k = 0; k < 7; k++) begin
      sq = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [7:0] byte_at(input aes_block_t b, input int i);
    return b[127-8*i -: 8];
  endfunction
endpackage

// File: rtl/aes_key_step.sv
// aes_key_step: one AES-128 key-schedule step, combinational.
// Ports: rk = current round key, rcon = round constant, rk_n = next round key.
module aes_key_step import aes_pkg::*; (
  input  aes_block_t rk,
  input  logic [7:0] rcon,
  output aes_block_t rk_n
);
  logic [31:0] t, w0, w1, w2, w3;
  always_comb begin
    t = {sbox(rk[23:16]), sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])} ^ {rcon, 24'h0};
    w0 = rk[127:96] ^ t;
    w1 = rk[95:64] ^ w0;
    w2 = rk[63:32] ^ w1;
    w3 = rk[31:0] ^ w2;
  end
  assign rk_n = {w0, w1, w2, w3};
endmodule

// File: rtl/aes_stages.sv
// aes_stages: combinational AES round stages SubBytes, ShiftRows and MixColumns.
// Ports (each module): d = input block, q = transformed block; column-major byte order.
module aes_subbytes import aes_pkg::*; (
  input  aes_block_t d,
  output aes_block_t q
);
  for (genvar i = 0; i < 16; i++) begin : g_sb
    assign q[127-8*i -: 8] = sbox(byte_at(d, i));
  end
endmodule

module aes_shiftrows import aes_pkg::*; (
  input  aes_block_t d,
  output aes_block_t q
);
  // Row r rotates left by r columns: out(r,c) = in(r,(c+r)%4).
  for (genvar i = 0; i < 16; i++) begin : g_sr
    assign q[127-8*i -: 8] = byte_at(d, i % 4 + 4 * ((i / 4 + i % 4) % 4));
  end
endmodule

module aes_mixcolumns import aes_pkg::*; (
  input  aes_block_t d,
  output aes_block_t q
);
  // b_j = 2a_j ^ 3a_{j+1} ^ a_{j+2} ^ a_{j+3}, folded as xtime(a_j^a_{j+1}) ^ a_{j+1} ^ a_{j+2} ^ a_{j+3}.
  for (genvar i = 0; i < 16; i++) begin : g_mc
    localparam int C = i - i % 4;
    logic [7:0] a0, a1, a2, a3;
    assign a0 = byte_at(d, i);
    assign a1 = byte_at(d, C + (i + 1) % 4);
    assign a2 = byte_at(d, C + (i + 2) % 4);
    assign a3 = byte_at(d, C + (i + 3) % 4);
    assign q[127-8*i -: 8] = xtime(a0 ^ a1) ^ a1 ^ a2 ^ a3;
  end
endmodule

// File: rtl/aes128_enc_ctrl.sv
// aes128_enc_ctrl: iterative AES-128 encryption sequencer, one round per clock.
// Ports: clk, rst (async, active-high), start, key_in, data_in -> busy, done (1-cycle pulse),
// data_out (held until next completion), round_o (round to execute next, 0 when idle).
// Optional abort input when AES_CTRL_ABORT_EN is defined: abandons a run without done.
module aes128_enc_ctrl import aes_pkg::*; #(
  parameter int NR = aes_pkg::NR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
`ifdef AES_CTRL_ABORT_EN
  input  logic         abort,
`endif
  input  logic [127:0] key_in,
  input  logic [127:0] data_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] data_out,
  output logic [3:0]   round_o
);
  aes_block_t state_q, state_d, rk_q, rk_d, data_out_q, data_out_d, rk_n, sb, sr, mc, rnd;
  logic [7:0] rcon_q, rcon_d;
  logic [3:0] round_q, round_d;
  logic busy_q, busy_d, done_q, done_d, last, kill;
  fsm_e fsm_q, fsm_d;
`ifdef AES_CTRL_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif
  aes_key_step   u_ks (.rk(rk_q), .rcon(rcon_q), .rk_n(rk_n));
  aes_subbytes   u_sb (.d(state_q), .q(sb));
  aes_shiftrows  u_sr (.d(sb), .q(sr));
  aes_mixcolumns u_mc (.d(sr), .q(mc));
  // The final round skips MixColumns.
  assign last = round_q == 4'(NR);
  assign rnd = (last ? sr : mc) ^ rk_n;
  always_comb begin
    fsm_d = fsm_q;
    state_d = state_q;
    rk_d = rk_q;
    rcon_d = rcon_q;
    round_d = round_q;
    busy_d = busy_q;
    done_d = 1'b0;
    data_out_d = data_out_q;
    if (fsm_q == IDLE && start) begin
      fsm_d = RUN;
      state_d = data_in ^ key_in;
      rk_d = key_in;
      rcon_d = RCON_INIT;
      round_d = 4'd1;
      busy_d = 1'b1;
    end else if (fsm_q == RUN && kill) begin
      fsm_d = IDLE;
      round_d = 4'd0;
      busy_d = 1'b0;
    end else if (fsm_q == RUN) begin
      fsm_d = last ? IDLE : RUN;
      state_d = rnd;
      rk_d = rk_n;
      rcon_d = xtime(rcon_q);
      round_d = last ? 4'd0 : round_q + 4'd1;
      busy_d = !last;
      done_d = last;
      data_out_d = last ? rnd : data_out_q;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q <= IDLE;
      state_q <= '0;
      rk_q <= '0;
      rcon_q <= '0;
      round_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      data_out_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      state_q <= state_d;
      rk_q <= rk_d;
      rcon_q <= rcon_d;
      round_q <= round_d;
      busy_q <= busy_d;
      done_q <= done_d;
      data_out_q <= data_out_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign data_out = data_out_q;
  assign round_o = round_q;
endmodule

// File: tb/tb_aes128_enc_ctrl.sv
// tb_aes128_enc_ctrl: self-checking bench for aes128_enc_ctrl using FIPS-197 vectors.
module tb_aes128_enc_ctrl;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] S1 = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C0 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    bit           scr;
    logic [127:0] ct;
  } vec_t;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [127:0] key_in = '0, data_in = '0;
  logic busy, done;
  logic [127:0] data_out;
  logic [3:0] round_o;
`ifdef AES_CTRL_ABORT_EN
  logic abort = 1'b0;
`endif
  int checks = 0, errors = 0;
  vec_t v[4];

  aes128_enc_ctrl dut (
    .clk(clk),
    .rst(rst),
    .start(start),
`ifdef AES_CTRL_ABORT_EN
    .abort(abort),
`endif
    .key_in(key_in),
    .data_in(data_in),
    .busy(busy),
    .done(done),
    .data_out(data_out),
    .round_o(round_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_enc(input logic [127:0] key, input logic [127:0] pt, input bit scr);
    @(negedge clk);
    start = 1'b1;
    key_in = key;
    data_in = pt;
    cyc();
    start = 1'b0;
    if (scr) begin
      key_in = '1;
      data_in = '1;
    end
    chk("busy_after_start", busy, 1);
    chk("round_after_start", round_o, 1);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      lat = k;
      if (done) break;
      if (k < 10) chk("round_seq", round_o, k + 1);
    end
    chk("done_seen", done, 1);
    chk("busy_at_done", busy, 0);
    chk("round_at_done", round_o, 0);
  endtask

  initial begin
    int lat;
    bit seen;
    v[0] = '{K1, P1, 1'b0, C1};
    v[1] = '{K2, P2, 1'b0, C2};
    v[2] = '{'0, '0, 1'b0, C0};
    v[3] = '{K1, P1, 1'b1, C1};
    #1 rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_round", round_o, 0);
    chk("rst_state", dut.state_q, 0);
    chk("rst_rk", dut.rk_q, 0);
    chk("rst_rcon", dut.rcon_q, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      start_enc(v[i].key, v[i].pt, v[i].scr);
      if (i == 0) chk("state_after_start", dut.state_q, S1);
      wait_done(lat);
      chk($sformatf("latency_%0d", i), lat, 10);
      chk($sformatf("ct_%0d", i), data_out, v[i].ct);
      cyc();
      chk("done_pulse_width", done, 0);
      chk("data_out_hold", data_out, v[i].ct);
    end

    @(negedge clk);
    start = 1'b1;
    key_in = K1;
    data_in = P1;
    for (int k = 0; k <= 40; k++) begin
      int m;
      cyc();
      m = k % 11;
      chk($sformatf("b2b_done_%0d", k), done, m == 10);
      chk($sformatf("b2b_busy_%0d", k), busy, m != 10);
      chk($sformatf("b2b_round_%0d", k), round_o, m == 10 ? 0 : m + 1);
      if (m == 10) chk($sformatf("b2b_ct_%0d", k), data_out, C1);
    end
    start = 1'b0;
    for (int k = 0; k < 15 && busy; k++) cyc();

    start_enc(K1, P1, 1'b0);
    repeat (4) cyc();
    chk("round_before_rst", round_o, 5);
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_data_out", data_out, 0);
    chk("midrst_round", round_o, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      cyc();
      seen |= done | busy;
    end
    chk("no_activity_after_rst", seen, 0);
    start_enc(K2, P2, 1'b0);
    wait_done(lat);
    chk("post_rst_ct", data_out, C2);

`ifdef AES_CTRL_ABORT_EN
    start_enc(K1, P1, 1'b0);
    repeat (3) cyc();
    chk("round_before_abort", round_o, 4);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_round", round_o, 0);
    chk("abort_data_out", data_out, C2);
    seen = 1'b0;
    repeat (12) begin
      cyc();
      seen |= done;
    end
    chk("abort_no_done", seen, 0);
    start_enc(K1, P1, 1'b0);
    repeat (9) cyc();
    chk("round_before_abort10", round_o, 10);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort10_done", done, 0);
    chk("abort10_busy", busy, 0);
    chk("abort10_data_out", data_out, C2);
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    key_in = K1;
    data_in = P1;
    cyc();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_idle_busy", busy, 1);
    wait_done(lat);
    chk("abort_idle_ct", data_out, C1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
